// File: rtl/ppa_pkg.sv
// Shared definitions for the ppa_arb block: sizes, result-register FSM
// encoding and the registered result payload.
package ppa_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned W     = 16;
    localparam int unsigned IDW   = 2;
    localparam int unsigned CNT_W = 16;

    // Result-register occupancy; encoding is fixed (EMPTY=0, FULL=1).
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } res_state_e;

    typedef struct packed {
        logic           co;
        logic [W-1:0]   sum;
        logic [IDW-1:0] id;
    } res_t;

endpackage

// File: rtl/ppa.sv
// 16-bit Kogge-Stone parallel-prefix adder (combinational).
// Ports: a, b - operands; s - sum mod 2^16; co - carry-out.
module ppa (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] s,
    output logic        co
);

    localparam int unsigned N   = 16;
    localparam int unsigned LVL = 4;

    logic [LVL:0][N-1:0] g;
    logic [LVL:0][N-1:0] p;

    // Prefix tree: level l combines spans 2^(l-1) apart.
    always_comb begin
        g    = '0;
        p    = '0;
        g[0] = a & b;
        p[0] = a ^ b;
        for (int l = 1; l <= int'(LVL); l++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (i >= (1 << (l - 1))) begin
                    g[l][i] = g[l-1][i] | (p[l-1][i] & g[l-1][i - (1 << (l - 1))]);
                    p[l][i] = p[l-1][i] & p[l-1][i - (1 << (l - 1))];
                end else begin
                    g[l][i] = g[l-1][i];
                    p[l][i] = p[l-1][i];
                end
            end
        end
    end

    // Group generate up to bit i-1 is the carry into bit i.
    assign s  = p[0] ^ {g[LVL][N-2:0], 1'b0};
    assign co = g[LVL][N-1];

endmodule

// File: rtl/rr_pick4.sv
// Round-robin selector for 4 requesters: picks the first valid index at or
// after ptr, wrapping 3->0.
// Ports: valid - request flags; ptr - priority pointer;
//        grant - one-hot pick (zero if none valid); idx - picked index.
module rr_pick4 (
    input  logic [3:0] valid,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic [1:0] idx
);

    logic       found;
    logic [1:0] cand;

    always_comb begin
        grant = '0;
        idx   = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/ppa_arb.sv
// Round-robin front end sharing one ppa adder among 4 requesters, with a
// single-entry result register that can drain and refill in the same cycle.
// Ports: clk, rst (sync, active-high); req_valid/req_ready - per-requester
//        handshake (req_ready combinational); req_a/req_b - packed operands;
//        res_valid/res_ready - result handshake; res_sum/res_co/res_id -
//        registered result; op_count - wrapping count of result handshakes.
module ppa_arb
    import ppa_pkg::*;
#(
    parameter int unsigned NREQ = ppa_pkg::NREQ,
    parameter int unsigned W    = ppa_pkg::W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [W-1:0]        res_sum,
    output logic                res_co,
    output logic [IDW-1:0]      res_id,
    output logic [CNT_W-1:0]    op_count
);

    res_state_e       state_q, state_d;
    res_t             res_q, res_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic [NREQ-1:0]  pick_grant;
    logic [IDW-1:0]   pick_idx;
    logic [W-1:0]     a_sel, b_sel;
    logic [W-1:0]     add_sum;
    logic             add_co;
    logic             can_accept_c;
    logic             req_hs_c;
    logic             res_hs_c;

    rr_pick4 u_pick (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Operand mux for the picked requester.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (pick_idx == IDW'(i)) begin
                a_sel = req_a[i*int'(W) +: W];
                b_sel = req_b[i*int'(W) +: W];
            end
        end
    end

    ppa u_add (
        .a  (a_sel),
        .b  (b_sel),
        .s  (add_sum),
        .co (add_co)
    );

    // Handshakes and next-state; a held result blocks all grants.
    always_comb begin
        state_d      = state_q;
        res_d        = res_q;
        ptr_d        = ptr_q;
        op_count_d   = op_count_q;
        res_hs_c     = (state_q == ST_FULL) && res_ready;
        can_accept_c = (state_q == ST_EMPTY) || res_ready;
        req_ready    = (can_accept_c && !rst) ? pick_grant : '0;
        req_hs_c     = |req_ready;

        if (res_hs_c) begin
            op_count_d = op_count_q + CNT_W'(1);
        end

        if (req_hs_c) begin
            state_d   = ST_FULL;
            res_d.co  = add_co;
            res_d.sum = add_sum;
            res_d.id  = pick_idx;
            ptr_d     = pick_idx + IDW'(1);
        end else if (res_hs_c) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            res_q      <= '0;
            ptr_q      <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            res_q      <= res_d;
            ptr_q      <= ptr_d;
            op_count_q <= op_count_d;
        end
    end

    assign res_valid = (state_q == ST_FULL);
    assign res_sum   = res_q.sum;
    assign res_co    = res_q.co;
    assign res_id    = res_q.id;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_ppa_arb.sv
// Bench for ppa_arb: a per-cycle reference model checked on every falling
// edge, plus directed scenarios with literal expected values.
module tb_ppa_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_sum;
    logic        res_co;
    logic [1:0]  res_id;
    logic [15:0] op_count;

    int n_chk = 0;
    int n_err = 0;

    ppa_arb #(.NREQ(4), .W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_co    (res_co),
        .res_id    (res_id),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: state as it stands after the most recent rising edge.
    bit          mdl_on   = 1'b0;
    bit          m_full   = 1'b0;
    logic [16:0] m_res    = '0;
    int          m_id     = 0;
    int          m_ptr    = 0;
    int          m_cnt    = 0;
    int          m_grants = 0;

    always @(negedge clk) begin
        if (mdl_on) begin
            logic [3:0]  exp_ready;
            int          g;
            logic [16:0] sum17;
            exp_ready = '0;
            g = -1;
            if (!rst && (!m_full || res_ready)) begin
                for (int k = 0; k < 4; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % 4]) begin
                        g = (m_ptr + k) % 4;
                    end
                end
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            chk("mdl_req_ready", 32'(req_ready), 32'(exp_ready));
            chk("mdl_res_valid", 32'(res_valid), 32'(m_full));
            chk("mdl_op_count", 32'(op_count), 32'(m_cnt & 16'hFFFF));
            if (m_full) begin
                chk("mdl_result", {15'd0, res_co, res_sum}, {15'd0, m_res});
                chk("mdl_res_id", 32'(res_id), 32'(m_id));
            end
            if (rst) begin
                m_full = 1'b0;
                m_res  = '0;
                m_id   = 0;
                m_ptr  = 0;
                m_cnt  = 0;
            end else begin
                if (m_full && res_ready) m_cnt++;
                if (g >= 0) begin
                    sum17    = 17'(req_a[16*g +: 16]) + 17'(req_b[16*g +: 16]);
                    m_full   = 1'b1;
                    m_res    = sum17;
                    m_id     = g;
                    m_ptr    = (g + 1) % 4;
                    m_grants++;
                end else if (m_full && res_ready) begin
                    m_full = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int budget;
        rst       = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;

        // Reset: outputs cleared, no grants while rst is high.
        cyc();
        mdl_on = 1'b1;
        cyc();
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_res_sum", 32'(res_sum), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);

        // req0: 3 + 4.
        rst        = 1'b0;
        req_valid  = 4'b0001;
        req_a      = 64'h0000_0000_0000_0003;
        req_b      = 64'h0000_0000_0000_0004;
        res_ready  = 1'b1;
        #1;
        chk("t1_grant", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 4'b0000;
        chk("t1_valid", 32'(res_valid), 32'd1);
        chk("t1_sum", 32'(res_sum), 32'h0007);
        chk("t1_co", 32'(res_co), 32'd0);
        chk("t1_id", 32'(res_id), 32'd0);
        cyc();
        chk("t1_op_count", 32'(op_count), 32'd1);
        chk("t1_drained", 32'(res_valid), 32'd0);

        // req1: 0xFFFF + 1 wraps with carry.
        req_valid  = 4'b0010;
        req_a      = 64'h0000_0000_FFFF_0000;
        req_b      = 64'h0000_0000_0001_0000;
        #1;
        chk("t2_grant", 32'(req_ready), 32'h2);
        cyc();
        req_valid = 4'b0000;
        chk("t2_sum", 32'(res_sum), 32'h0000);
        chk("t2_co", 32'(res_co), 32'd1);
        chk("t2_id", 32'(res_id), 32'd1);
        cyc();
        chk("t2_op_count", 32'(op_count), 32'd2);

        // Reset pulse to return the pointer to 0.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t3_op_count_clr", 32'(op_count), 32'd0);

        // All four valid: grants 0,1,2,3,0, one result per cycle.
        req_valid = 4'hF;
        req_a     = 64'h0400_0300_0200_0100;
        req_b     = 64'h0003_0002_0001_0000;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            cyc();
            #1;
            chk("rr_id", 32'(res_id), 32'(k % 4));
            chk("rr_sum", 32'(res_sum), 32'(16'h0100 * (k % 4 + 1) + k % 4));
        end
        chk("rr_op_count", 32'(op_count), 32'd4);

        // Stall while FULL with req2 waiting: nothing moves.
        req_valid = 4'b0100;
        res_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("stall_grant", 32'(req_ready), 32'd0);
            chk("stall_sum", 32'(res_sum), 32'h0100);
            chk("stall_id", 32'(res_id), 32'd0);
            chk("stall_valid", 32'(res_valid), 32'd1);
            cyc();
        end
        res_ready = 1'b1;
        #1;
        chk("refill_grant", 32'(req_ready), 32'h4);
        cyc();
        req_valid = 4'b0000;
        res_ready = 1'b0;
        chk("refill_id", 32'(res_id), 32'd2);
        chk("refill_sum", 32'(res_sum), 32'h0302);
        chk("refill_op_count", 32'(op_count), 32'd5);

        // Reset while FULL discards the held result.
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rstfull_valid", 32'(res_valid), 32'd0);
        chk("rstfull_op_count", 32'(op_count), 32'd0);
        req_valid = 4'hF;
        #1;
        chk("rstfull_ptr0", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 4'b0000;
        res_ready = 1'b1;
        cyc();
        chk("rstfull_after", 32'(op_count), 32'd1);

        // Random traffic: 100 accepted operations.
        rst = 1'b1;
        cyc();
        rst    = 1'b0;
        base   = m_grants;
        budget = 0;
        while ((m_grants - base) < 100 && budget < 5000) begin
            req_valid = 4'($urandom_range(0, 15));
            req_a     = {$urandom, $urandom};
            req_b     = {$urandom, $urandom};
            res_ready = ($urandom_range(0, 3) != 0);
            cyc();
            budget++;
        end
        req_valid = 4'b0000;
        res_ready = 1'b1;
        cyc();
        cyc();
        chk("rand_accepted", 32'(m_grants - base), 32'd100);
        chk("rand_op_count", 32'(op_count), 32'd100);
        chk("rand_empty", 32'(res_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ppa_arb.md
PPA_ARB -- requirements
Module: ppa_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; only 4 is supported.
REQ-002 Parameter W, default 16, operand width; fixed by the shared 16-bit ppa adder.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  4  per-requester operand-valid flag.
REQ-006 req_a  input  64  packed operand A; requester i occupies bits [16i+15:16i].
REQ-007 req_b  input  64  packed operand B, same packing as req_a.
REQ-008 req_ready  output  4  one-hot grant/accept; at most one bit high per cycle.
REQ-009 res_valid  output  1  result register holds a valid result.
REQ-010 res_ready  input  1  consumer accepts the result.
REQ-011 res_sum  output  16  registered sum A+B mod 2^16.
REQ-012 res_co  output  1  registered carry-out of A+B.
REQ-013 res_id  output  2  index of the requester that produced the result.
REQ-014 op_count  output  16  number of completed result handshakes, wrapping.

Function
REQ-015 The block SHALL share one ppa adder instance among the 4 requesters, one addition per accepted request.
REQ-016 A request handshake SHALL occur on a cycle when req_valid[i] and req_ready[i] are both high.
REQ-017 A result handshake SHALL occur on a cycle when res_valid and res_ready are both high.
REQ-018 The result register SHALL be a 2-state FSM: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-019 The block SHALL set can_accept = EMPTY, or FULL with res_ready=1 (same-cycle drain and refill).
REQ-020 When can_accept=1 and any req_valid is high, the block SHALL assert req_ready for exactly one requester: the first valid index at or after the priority pointer, wrapping 3->0.
REQ-021 req_ready SHALL be combinational from req_valid, the pointer and the FSM state; it SHALL never be asserted for an invalid requester.
REQ-022 On a request handshake by requester g, the block SHALL load {res_co, res_sum} = A_g + B_g (17-bit) and res_id = g on the next edge, and SHALL enter FULL.
REQ-023 Latency SHALL be 1 cycle from the request handshake to res_valid.
REQ-024 On a request handshake by g, the pointer SHALL become (g+1) mod 4; otherwise it SHALL hold.
REQ-025 If FULL and res_ready=1 with no request handshake, the FSM SHALL go to EMPTY.
REQ-026 If FULL and res_ready=0, res_sum, res_co and res_id SHALL hold stable and req_ready SHALL be all zero.
REQ-027 op_count SHALL increment by 1 on each result handshake and SHALL wrap 0xFFFF->0x0000.
REQ-028 A requester dropping req_valid without a handshake SHALL have no effect.
REQ-029 With a continuously asserted res_ready, the block SHALL sustain one result per cycle.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL force FSM=EMPTY, res_valid=0, res_sum=0, res_co=0, res_id=0, pointer=0 and op_count=0.
REQ-031 While rst=1, req_ready SHALL be 0.
REQ-032 Reset mid-operation SHALL discard any held result without a result handshake and without an op_count increment.

Structure
REQ-033 NREQ, W and the FSM state encoding (EMPTY=0, FULL=1) SHALL live in the shared ppa_pkg package.
REQ-034 The adder SHALL be one instance of the existing ppa module; the 17-bit result is {CO, S}.
REQ-035 The round-robin selector SHALL be a separate sub-module rr_pick4 (inputs: valid[3:0], ptr[1:0]; outputs: one-hot grant, index).

Verification
REQ-036 Reset, then req0 A=0x0003 B=0x0004 with res_ready=1 -> next cycle res_valid=1, sum=0x0007, co=0, id=0, then op_count=1.
REQ-037 req1 A=0xFFFF B=0x0001 -> sum=0x0000, co=1, id=1.
REQ-038 All 4 valid continuously, res_ready=1, pointer=0 -> grant order 0,1,2,3,0; one result per cycle.
REQ-039 res_ready=0 for 5 cycles while FULL and req2 valid -> req_ready=0, outputs stable; res_ready=1 -> same-cycle drain plus req2 accepted.
REQ-040 rst pulsed while FULL with res_ready=0 -> res_valid=0, pointer=0, op_count unchanged by the dropped result.
REQ-041 100 random operand pairs from random requesters with random res_ready -> every {co,sum} equals A+B, id matches the originator, op_count=100.
